// File: rtl/npc_ctrl.sv
// npc_ctrl: next-PC selection for the five-stage MIPS pipeline.
// Picks the address the PC register loads on its next non-stalled edge.
// The sources are sequential fetch, ID-stage branch/jump/jr, exception
// entry and eret return. An exception or eret redirect that arrives while
// the pipeline is stalled is held until the PC register can accept it.
// The block also tracks whether the instruction at PC_F is a delay slot.
module npc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_F,
  input  logic [31:0] PC_D,
  input  logic        Stall,
  input  logic        IsBJ_D,
  input  logic        Br_D,
  input  logic [15:0] Imm_D,
  input  logic        J_D,
  input  logic [25:0] Index_D,
  input  logic        Jr_D,
  input  logic [31:0] RS_D,
  input  logic        Exc,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic [31:0] MPC_,
  output logic        BD_F,
  output logic        Pend
);

  // The PC register returns to RESET_PC on its own. This block only needs a
  // word-aligned reset address, so a misaligned one leaves a named marker
  // in the elaborated hierarchy for anyone inspecting the build.
  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_misaligned
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } pend_state_t;

  pend_state_t state, state_next;

  logic [31:0] pend_pc, pend_pc_next;
  logic        pend_exc, pend_exc_next;
  logic        pend_vld;
  logic        bd_next;

  logic [31:0] seq_target;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pend_vld = (state == HOLD);
  assign Pend     = pend_vld;

  // Candidate targets. All arithmetic wraps modulo 2^32. The jump region
  // comes from the delay-slot address PC_D+4, not from PC_D itself.
  always_comb begin
    seq_target = PC_F + 32'd4;
    pc_d_plus4 = PC_D + 32'd4;
    br_offset  = {{14{Imm_D[15]}}, Imm_D, 2'b00};
    br_target  = pc_d_plus4 + br_offset;
    j_target   = {pc_d_plus4[31:28], Index_D, 2'b00};
  end

  // Next-PC priority mux: exception, eret, held redirect, then ID control flow.
  always_comb begin
    MPC_ = seq_target;
    if (Exc) begin
      MPC_ = EXC_VEC;
    end else if (Eret) begin
      MPC_ = EPC;
    end else if (pend_vld) begin
      MPC_ = pend_pc;
    end else if (Jr_D) begin
      MPC_ = RS_D;
    end else if (J_D) begin
      MPC_ = j_target;
    end else if (Br_D) begin
      MPC_ = br_target;
    end
  end

  // Pending-redirect FSM. It latches exc/eret targets only while stalled.
  // An exception already held cannot be displaced by a later eret.
  always_comb begin
    state_next    = state;
    pend_pc_next  = pend_pc;
    pend_exc_next = pend_exc;
    case (state)
      IDLE: begin
        if (Stall && (Exc || Eret)) begin
          state_next    = HOLD;
          pend_pc_next  = Exc ? EXC_VEC : EPC;
          pend_exc_next = Exc;
        end
      end
      HOLD: begin
        if (Stall) begin
          if (Exc) begin
            pend_pc_next  = EXC_VEC;
            pend_exc_next = 1'b1;
          end else if (Eret && !pend_exc) begin
            pend_pc_next = EPC;
          end
        end else begin
          state_next    = IDLE;
          pend_exc_next = 1'b0;
        end
      end
      default: begin
        state_next    = IDLE;
        pend_exc_next = 1'b0;
      end
    endcase
  end

  // State register for the pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pend_pc  <= 32'h0000_0000;
      pend_exc <= 1'b0;
    end else begin
      state    <= state_next;
      pend_pc  <= pend_pc_next;
      pend_exc <= pend_exc_next;
    end
  end

  // A fetch is a delay slot only if the ID branch/jump is not pre-empted
  // by an exc/eret redirect. This covers one arriving now or one held.
  always_comb begin
    bd_next = IsBJ_D & ~Exc & ~Eret & ~pend_vld;
  end

  // Delay-slot flag: follows the fetch, frozen while the PC is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      BD_F <= 1'b0;
    end else if (!Stall) begin
      BD_F <= bd_next;
    end
  end

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: directed self-checking bench for npc_ctrl.
// Inputs change 1 time unit after a rising edge. Combinational MPC_ is
// checked 1 unit after that, and registered outputs after each edge.
module tb_npc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pcF;
  logic [31:0] pcD;
  logic        stall;
  logic        isBJ;
  logic        br;
  logic [15:0] imm;
  logic        jmp;
  logic [25:0] index;
  logic        jr;
  logic [31:0] rs;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] mpc;
  logic        bdF;
  logic        pend;

  int checkCount;
  int errorCount;

  npc_ctrl #(
    .RESET_PC(32'h0000_3000),
    .EXC_VEC (32'h0000_4180)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .PC_F   (pcF),
    .PC_D   (pcD),
    .Stall  (stall),
    .IsBJ_D (isBJ),
    .Br_D   (br),
    .Imm_D  (imm),
    .J_D    (jmp),
    .Index_D(index),
    .Jr_D   (jr),
    .RS_D   (rs),
    .Exc    (exc),
    .Eret   (eret),
    .EPC    (epc),
    .MPC_   (mpc),
    .BD_F   (bdF),
    .Pend   (pend)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its expected value and counts it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advances one rising edge and leaves time just past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Drops every request back to an idle pattern.
  task automatic clearInputs();
    stall = 1'b0; isBJ = 1'b0; br = 1'b0; imm = 16'h0000;
    jmp = 1'b0; index = 26'h0; jr = 1'b0; rs = 32'h0;
    exc = 1'b0; eret = 1'b0; epc = 32'h0; pcD = 32'h0;
  endtask

  // Directed sequence.
  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    pcF   = 32'h0000_3000;
    clearInputs();
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("reset_mpc", mpc, 32'h0000_3004);
    checkOutput("reset_bd", {31'b0, bdF}, 32'h0);
    checkOutput("reset_pend", {31'b0, pend}, 32'h0);

    // Backward branch and delay-slot flag.
    pcD = 32'h0000_3010; br = 1'b1; imm = 16'hFFFC; isBJ = 1'b1;
    #1;
    checkOutput("br_back", mpc, 32'h0000_3004);
    applyStimulus();
    checkOutput("br_bd_set", {31'b0, bdF}, 32'h1);
    stall = 1'b1; isBJ = 1'b0; br = 1'b0;
    applyStimulus();
    checkOutput("bd_hold_stall", {31'b0, bdF}, 32'h1);
    stall = 1'b0;
    applyStimulus();
    checkOutput("bd_clear", {31'b0, bdF}, 32'h0);

    // Forward branch.
    pcD = 32'h0000_3000; br = 1'b1; imm = 16'h0010;
    #1;
    checkOutput("br_fwd", mpc, 32'h0000_3044);
    br = 1'b0;

    // Jumps, including region wrap through PC_D+4.
    pcD = 32'hFFFF_FFFC; jmp = 1'b1; index = 26'h0000040;
    #1;
    checkOutput("j_wrap", mpc, 32'h0000_0100);
    pcD = 32'h1234_5670; index = 26'h0ABCDEF;
    #1;
    checkOutput("j_region", mpc, 32'h12AF_37BC);

    // jr beats j and branch.
    jr = 1'b1; rs = 32'h0000_3400; br = 1'b1;
    #1;
    checkOutput("jr_prio", mpc, 32'h0000_3400);
    clearInputs();
    applyStimulus();

    // Exception under stall.
    pcD = 32'h0000_3010; imm = 16'hFFFC;
    stall = 1'b1; exc = 1'b1; br = 1'b1; isBJ = 1'b1;
    #1;
    checkOutput("exc_direct", mpc, 32'h0000_4180);
    applyStimulus();
    exc = 1'b0;
    #1;
    checkOutput("exc_pend", {31'b0, pend}, 32'h1);
    checkOutput("exc_held_mpc", mpc, 32'h0000_4180);
    applyStimulus();
    checkOutput("exc_still_pend", {31'b0, pend}, 32'h1);
    stall = 1'b0;
    #1;
    checkOutput("exc_release_mpc", mpc, 32'h0000_4180);
    applyStimulus();
    checkOutput("exc_release_pend", {31'b0, pend}, 32'h0);
    checkOutput("exc_release_bd", {31'b0, bdF}, 32'h0);
    checkOutput("br_after_release", mpc, 32'h0000_3004);

    // Unstalled exception never latches and suppresses the delay slot.
    exc = 1'b1;
    applyStimulus();
    exc = 1'b0;
    #1;
    checkOutput("exc_nostall_pend", {31'b0, pend}, 32'h0);
    checkOutput("exc_nostall_bd", {31'b0, bdF}, 32'h0);
    clearInputs();
    applyStimulus();

    // Eret, then Exc during the same stall; later Eret must not overwrite.
    stall = 1'b1; eret = 1'b1; epc = 32'h0000_3020;
    #1;
    checkOutput("eret_direct", mpc, 32'h0000_3020);
    applyStimulus();
    eret = 1'b0; epc = 32'hDEAD_0000;
    #1;
    checkOutput("eret_held", mpc, 32'h0000_3020);
    applyStimulus();
    exc = 1'b1;
    applyStimulus();
    exc = 1'b0;
    #1;
    checkOutput("exc_over_eret", mpc, 32'h0000_4180);
    eret = 1'b1; epc = 32'h0000_3080;
    #1;
    checkOutput("eret_comb_prio", mpc, 32'h0000_3080);
    applyStimulus();
    eret = 1'b0;
    #1;
    checkOutput("eret_no_overwrite", mpc, 32'h0000_4180);
    checkOutput("hold_pend", {31'b0, pend}, 32'h1);

    // Reset while holding discards the redirect.
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("rst_hold_pend", {31'b0, pend}, 32'h0);
    checkOutput("rst_hold_bd", {31'b0, bdF}, 32'h0);
    checkOutput("rst_hold_mpc", mpc, 32'h0000_3004);

    // Eret over eret does overwrite; a same-cycle eret at release wins.
    eret = 1'b1; epc = 32'h0000_3020;
    applyStimulus();
    epc = 32'h0000_3040;
    applyStimulus();
    eret = 1'b0;
    #1;
    checkOutput("eret_overwrite", mpc, 32'h0000_3040);
    stall = 1'b0; eret = 1'b1; epc = 32'h0000_3100;
    #1;
    checkOutput("release_eret_wins", mpc, 32'h0000_3100);
    applyStimulus();
    eret = 1'b0;
    #1;
    checkOutput("release_eret_pend", {31'b0, pend}, 32'h0);
    checkOutput("release_eret_mpc", mpc, 32'h0000_3004);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
